muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 122 ++++++++++++
 tb/tb_muldiv_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with register-file writeback port.
// One product or quotient bit is resolved per clock; results are written back from DONE.
module muldiv_unit #(
    parameter int n = 16,
    parameter int r = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [r-1:0] dst,
    output logic         busy,
    output logic         done,
    output logic         we,
    output logic [r-1:0] wa,
    output logic [n-1:0] wd
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_op;
    logic [n-1:0]   r_b;
    logic [r-1:0]   r_dst;
    logic [2*n-1:0] r_acc;
    logic           r_busy;
    logic           r_done;
    logic           r_we;
    logic [r-1:0]   r_wa;
    logic [n-1:0]   r_wd;

    logic           w_accept;
    logic           w_lastIter;
    logic [n-1:0]   w_addend;
    logic [n:0]     w_sum;
    logic [n:0]     w_shifted;
    logic           w_fits;
    logic [n-1:0]   w_diff;
    logic [2*n-1:0] w_accNext;
    logic [n-1:0]   w_result;

    always_comb begin
        w_accept    = start && (r_state != RUN);
        w_lastIter  = (r_state == RUN) && (r_cnt == CW'(n - 1));
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_stateNext = RUN;
            RUN:     if (w_lastIter) w_stateNext = DONE;
            DONE:    w_stateNext = w_accept ? RUN : IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Multiply keeps {partial product, multiplier} and shifts right; divide keeps
    // {remainder, dividend/quotient} and shifts left. A zero divisor always "fits",
    // which naturally yields an all-ones quotient and a remainder equal to a.
    always_comb begin
        w_addend  = r_acc[0] ? r_b : '0;
        w_sum     = {1'b0, r_acc[2*n-1:n]} + {1'b0, w_addend};
        w_shifted = {r_acc[2*n-1:n], r_acc[n-1]};
        w_fits    = w_shifted >= {1'b0, r_b};
        w_diff    = w_shifted[n-1:0] - r_b;
        if (!r_op[1]) begin
            w_accNext = {w_sum, r_acc[n-1:1]};
        end else if (w_fits) begin
            w_accNext = {w_diff, r_acc[n-2:0], 1'b1};
        end else begin
            w_accNext = {r_acc[2*n-2:0], 1'b0};
        end
        w_result = r_op[0] ? w_accNext[2*n-1:n] : w_accNext[n-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_b     <= '0;
            r_dst   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_wa    <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_stateNext;
            r_busy  <= (w_stateNext == RUN);
            r_done  <= w_lastIter;
            r_we    <= w_lastIter && (r_dst != '0);
            r_wa    <= w_lastIter ? r_dst : '0;
            r_wd    <= w_lastIter ? w_result : '0;
            if (w_accept) begin
                r_op  <= op;
                r_b   <= b;
                r_dst <= dst;
                r_acc <= {{n{1'b0}}, a};
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_acc <= w_accNext;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign we   = r_we;
    assign wa   = r_wa;
    assign wd   = r_wd;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected writebacks are queued at start
// and compared when done pulses.
module tb_muldiv_unit;

    localparam int N = 16;
    localparam int R = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [R-1:0] dst = '0;
    logic         busy;
    logic         done;
    logic         we;
    logic [R-1:0] wa;
    logic [N-1:0] wd;

    typedef struct packed {
        logic         we;
        logic [R-1:0] wa;
        logic [N-1:0] wd;
    } exp_t;

    exp_t expQ[$];
    int compared   = 0;
    int mismatched = 0;
    int tickCount  = 0;
    int busyCount  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.n(N), .r(R)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .dst     (dst),
        .busy    (busy),
        .done    (done),
        .we      (we),
        .wa      (wa),
        .wd      (wd)
    );

    function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        case (o)
            2'd0:    return p[N-1:0];
            2'd1:    return p[2*N-1:N];
            2'd2:    return (y == 0) ? {N{1'b1}} : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        tickCount++;
        if (busy === 1'b1) busyCount++;
    endtask

    task automatic startOp(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                           input logic [R-1:0] d, input bit expectAccept);
        exp_t e;
        op = o; a = x; b = y; dst = d; start = 1'b1;
        if (expectAccept) begin
            e.we = (d != 0);
            e.wa = d;
            e.wd = model(o, x, y);
            expQ.push_back(e);
        end
    endtask

    task automatic waitDone(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        startOp(2'd0, 16'd5, 16'd5, 3'd1, 1'b0);
        tick();
        tick();
        compared += 5;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
        if (we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we got %b want 0", we); end
        if (wa !== '0) begin mismatched++; $display("[TB] FAIL reset_wa got %0d want 0", wa); end
        if (wd !== '0) begin mismatched++; $display("[TB] FAIL reset_wd got %h want 0", wd); end
        reset_n = 1'b1;
        start = 1'b0;
        tick();
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    endtask

    // Runs a table of operations, checking latency, busy length and writeback for each.
    task automatic runTable(input string name, input logic [1:0] ops[], input logic [N-1:0] as[],
                            input logic [N-1:0] bs[], input logic [R-1:0] ds[]);
        bit   seen;
        int   startTick;
        exp_t e;
        exp_t got;
        for (int i = 0; i < ops.size(); i++) begin
            startOp(ops[i], as[i], bs[i], ds[i], 1'b1);
            startTick = tickCount;
            busyCount = 0;
            tick();
            start = 1'b0;
            waitDone(seen);
            compared++;
            if (!seen) begin
                mismatched++;
                $display("[TB] FAIL %s_%0d_timeout got no done want done", name, i);
                void'(expQ.pop_front());
                continue;
            end
            compared += 3;
            if (tickCount - startTick != 17) begin
                mismatched++;
                $display("[TB] FAIL %s_%0d_latency got %0d want 17", name, i, tickCount - startTick);
            end
            if (busyCount != 16) begin
                mismatched++;
                $display("[TB] FAIL %s_%0d_busy_cycles got %0d want 16", name, i, busyCount);
            end
            e = expQ.pop_front();
            got = {we, wa, wd};
            if (got !== e) begin
                mismatched++;
                $display("[TB] FAIL %s_%0d_result got we=%b wa=%0d wd=%h want we=%b wa=%0d wd=%h",
                         name, i, we, wa, wd, e.we, e.wa, e.wd);
            end
            tick();
            compared++;
            if (done !== 1'b0 || busy !== 1'b0 || we !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL %s_%0d_post_done got done=%b busy=%b we=%b want 0 0 0",
                         name, i, done, busy, we);
            end
        end
    endtask

    task automatic test_mul;
        runTable("mul", '{2'd0, 2'd0, 2'd1}, '{16'd7, 16'hFFFF, 16'hFFFF},
                 '{16'd6, 16'hFFFF, 16'hFFFF}, '{3'd3, 3'd5, 3'd6});
    endtask

    task automatic test_div;
        runTable("div", '{2'd2, 2'd3, 2'd2, 2'd3, 2'd2}, '{16'd100, 16'd100, 16'h1234, 16'h1234, 16'hBEEF},
                 '{16'd7, 16'd7, 16'd0, 16'd0, 16'd13}, '{3'd1, 3'd2, 3'd4, 3'd7, 3'd3});
    endtask

    task automatic test_start_while_busy;
        bit   seen;
        int   startTick;
        int   extraDone;
        exp_t e;
        startOp(2'd2, 16'd100, 16'd7, 3'd2, 1'b1);
        startTick = tickCount;
        tick();
        start = 1'b0;
        repeat (4) tick();
        startOp(2'd0, 16'd9, 16'd9, 3'd5, 1'b0);
        tick();
        start = 1'b0;
        waitDone(seen);
        compared++;
        if (!seen) begin
            mismatched++;
            $display("[TB] FAIL busy_start_timeout got no done want done");
            void'(expQ.pop_front());
        end else begin
            compared += 2;
            if (tickCount - startTick != 17) begin
                mismatched++;
                $display("[TB] FAIL busy_start_latency got %0d want 17", tickCount - startTick);
            end
            e = expQ.pop_front();
            if ({we, wa, wd} !== e) begin
                mismatched++;
                $display("[TB] FAIL busy_start_result got we=%b wa=%0d wd=%h want we=%b wa=%0d wd=%h",
                         we, wa, wd, e.we, e.wa, e.wd);
            end
        end
        extraDone = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extraDone++;
        end
        compared++;
        if (extraDone != 0) begin
            mismatched++;
            $display("[TB] FAIL busy_start_extra got %0d active cycles want 0", extraDone);
        end
    endtask

    task automatic test_back_to_back;
        bit   seen;
        int   startTick;
        exp_t e;
        startOp(2'd0, 16'd3, 16'd5, 3'd1, 1'b1);
        tick();
        start = 1'b0;
        waitDone(seen);
        compared++;
        if (!seen) begin
            mismatched++;
            $display("[TB] FAIL b2b_first_timeout got no done want done");
            void'(expQ.pop_front());
        end else begin
            compared++;
            e = expQ.pop_front();
            if ({we, wa, wd} !== e) begin
                mismatched++;
                $display("[TB] FAIL b2b_first_result got we=%b wa=%0d wd=%h want we=%b wa=%0d wd=%h",
                         we, wa, wd, e.we, e.wa, e.wd);
            end
        end
        startOp(2'd0, 16'h1234, 16'd3, 3'd0, 1'b1);
        startTick = tickCount;
        tick();
        start = 1'b0;
        waitDone(seen);
        compared++;
        if (!seen) begin
            mismatched++;
            $display("[TB] FAIL b2b_second_timeout got no done want done");
            void'(expQ.pop_front());
        end else begin
            compared += 2;
            if (tickCount - startTick != 17) begin
                mismatched++;
                $display("[TB] FAIL b2b_second_latency got %0d want 17", tickCount - startTick);
            end
            e = expQ.pop_front();
            if ({we, wa, wd} !== e) begin
                mismatched++;
                $display("[TB] FAIL b2b_r0_result got we=%b wa=%0d wd=%h want we=%b wa=%0d wd=%h",
                         we, wa, wd, e.we, e.wa, e.wd);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_run;
        bit   seen;
        int   startTick;
        int   stray;
        exp_t e;
        startOp(2'd0, 16'd7, 16'd6, 3'd3, 1'b0);
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_state got busy=%b done=%b we=%b want 0 0 0", busy, done, we);
        end
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done === 1'b1 || we === 1'b1 || busy === 1'b1) stray++;
        end
        compared++;
        if (stray != 0) begin
            mismatched++;
            $display("[TB] FAIL abort_stray got %0d active cycles want 0", stray);
        end
        startOp(2'd1, 16'd7, 16'd6, 3'd2, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        startOp(2'd3, 16'd1000, 16'd33, 3'd6, 1'b1);
        startTick = tickCount;
        tick();
        start = 1'b0;
        waitDone(seen);
        compared++;
        if (!seen) begin
            mismatched++;
            $display("[TB] FAIL post_reset_timeout got no done want done");
            void'(expQ.pop_front());
        end else begin
            compared += 2;
            if (tickCount - startTick != 17) begin
                mismatched++;
                $display("[TB] FAIL post_reset_latency got %0d want 17", tickCount - startTick);
            end
            e = expQ.pop_front();
            if ({we, wa, wd} !== e) begin
                mismatched++;
                $display("[TB] FAIL post_reset_result got we=%b wa=%0d wd=%h want we=%b wa=%0d wd=%h",
                         we, wa, wd, e.we, e.wa, e.wd);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain got %0d pending want 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
